// File: rtl/pmem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the pc geometry, the fetch FSM encoding and the compressed-instruction test.
package pmem_fetch_pkg;

   localparam int              PC_W     = 17;
   localparam logic [PC_W-1:0] RESET_PC = '0;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // Any opcode whose two low bits are not 11 is a 16-bit instruction.
   function automatic logic is_compressed(input logic [1:0] lo);
      return lo != 2'b11;
   endfunction

endpackage

// File: rtl/pmem_fetch_if.sv
// Program-memory read port plus the fetch-to-decode handshake.
// The master modport is the fetch stage; the slave side is memory and decode.
interface pmem_fetch_if;

   logic [pmem_fetch_pkg::PC_W-1:0] pc;
   logic [31:0]                     instr;
   logic                            dec_ready;
   logic                            if_valid;
   logic [31:0]                     if_instr;
   logic [pmem_fetch_pkg::PC_W-1:0] if_pc;
   logic                            if_is_c;

   modport master (
      output pc,
      input  instr,
      input  dec_ready,
      output if_valid,
      output if_instr,
      output if_pc,
      output if_is_c
   );

   modport slave (
      input  pc,
      output instr,
      output dec_ready,
      input  if_valid,
      input  if_instr,
      input  if_pc,
      input  if_is_c
   );

endinterface

// File: rtl/pmem_fetch.sv
// Instruction fetch: drives the program-memory pc, registers the returned word for decode,
// and sequences boot hold, redirects and halt.
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | loader owns program memory; pc parked at RESET_PC, no output
// RUN   | fetching one instruction per accepted cycle
// HALT  | fetch stopped; waits for a redirect or a return to boot
module pmem_fetch #(
   parameter logic [pmem_fetch_pkg::PC_W-1:0] RESET_PC = pmem_fetch_pkg::RESET_PC
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            boot_hold,
   input  logic                            redirect_valid,
   input  logic [pmem_fetch_pkg::PC_W-1:0] redirect_pc,
   input  logic                            halt_req,
   output logic                            if_misalign,
   output logic                            halted,
   pmem_fetch_if.master                    bus
);

   import pmem_fetch_pkg::*;

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] if_pc_q, if_pc_d;
   logic [31:0]     if_instr_q, if_instr_d;
   logic            valid_q, valid_d;
   logic            is_c_q, is_c_d;
   logic            mis_q, mis_d;

   logic            instr_c;
   logic            accept;
   logic [PC_W-1:0] redir_tgt;

   assign instr_c   = is_compressed(bus.instr[1:0]);
   assign accept    = !valid_q || bus.dec_ready;
   assign redir_tgt = {redirect_pc[PC_W-1:1], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         valid_q    <= 1'b0;
         is_c_q     <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         valid_q    <= valid_d;
         is_c_q     <= is_c_d;
         mis_q      <= mis_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      valid_d    = valid_q;
      is_c_d     = is_c_q;
      mis_d      = mis_q;

      if (boot_hold) begin
         state_d = BOOT;
         pc_d    = RESET_PC;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            BOOT: begin
               state_d = RUN;
               pc_d    = RESET_PC;
            end
            RUN, HALT: begin
               if (redirect_valid) begin
                  state_d = RUN;
                  pc_d    = redir_tgt;
                  valid_d = 1'b0;
                  mis_d   = mis_q | redirect_pc[0];
               end else if (state_q == RUN) begin
                  if (halt_req) begin
                     state_d = HALT;
                     valid_d = 1'b0;
                  end else if (accept) begin
                     if_instr_d = instr_c ? {16'h0000, bus.instr[15:0]} : bus.instr;
                     if_pc_d    = pc_q;
                     is_c_d     = instr_c;
                     valid_d    = 1'b1;
                     // Wraps modulo 2^PC_W by truncation.
                     pc_d       = pc_q + (instr_c ? PC_W'(2) : PC_W'(4));
                  end
               end
            end
            default: begin
               state_d = BOOT;
               pc_d    = RESET_PC;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.pc       = pc_q;
   assign bus.if_valid = valid_q;
   assign bus.if_instr = if_instr_q;
   assign bus.if_pc    = if_pc_q;
   assign bus.if_is_c  = is_c_q;
   assign if_misalign  = mis_q;
   assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_pmem_fetch.sv
// Self-checking bench for pmem_fetch: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the fetch rules.
module tb_pmem_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        boot_hold;
   logic        redirect_valid;
   logic [16:0] redirect_pc;
   logic        halt_req;
   logic        if_misalign;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   pmem_fetch_if dif ();

   pmem_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .boot_hold      (boot_hold),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .if_misalign    (if_misalign),
      .halted         (halted),
      .bus            (dif)
   );

   always #5 clk = ~clk;

   // Halfword-organised program memory; read data is combinational from pc.
   logic [15:0] mem [0:65535];
   logic [15:0] rd_lo, rd_hi;
   assign rd_lo     = dif.pc[16:1];
   assign rd_hi     = rd_lo + 16'd1;
   assign dif.instr = {mem[rd_hi], mem[rd_lo]};

   // Reference model: state 0=boot, 1=run, 2=halt.
   int          m_st;
   logic [16:0] m_pc, m_if_pc;
   logic [31:0] m_instr;
   logic        m_v, m_c, m_mis;

   function automatic void model_reset();
      m_st = 0; m_pc = '0; m_if_pc = '0; m_instr = '0;
      m_v = 1'b0; m_c = 1'b0; m_mis = 1'b0;
   endfunction

   function automatic void model_step();
      logic [15:0] lo, hi;
      logic [31:0] w;
      logic        c;
      if (boot_hold) begin
         m_st = 0; m_pc = '0; m_v = 1'b0;
      end else if (m_st == 0) begin
         m_st = 1;
      end else if (redirect_valid) begin
         m_st = 1;
         m_pc = redirect_pc & 17'h1FFFE;
         m_v  = 1'b0;
         if (redirect_pc[0]) m_mis = 1'b1;
      end else if (m_st == 1 && halt_req) begin
         m_st = 2; m_v = 1'b0;
      end else if (m_st == 1 && (!m_v || dif.dec_ready)) begin
         lo = m_pc[16:1];
         hi = lo + 16'd1;
         w  = {mem[hi], mem[lo]};
         c  = (w[1:0] != 2'b11);
         m_instr = c ? (w & 32'h0000FFFF) : w;
         m_if_pc = m_pc;
         m_c     = c;
         m_v     = 1'b1;
         m_pc    = 17'((32'(m_pc) + (c ? 2 : 4)) % 131072);
      end
   endfunction

   // Advance one rising edge (model first, from pre-edge inputs), then settle.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; boot_hold = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; halt_req = 1'b0; dif.dec_ready = 1'b1;
      model_reset();
      #3;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; boot_hold = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; halt_req = 1'b0; dif.dec_ready = 1'b1;
      model_reset();
      #2;
      checks++;
      if ({dif.pc, dif.if_valid, dif.if_instr, dif.if_pc, dif.if_is_c, if_misalign, halted} !== '0) begin
         failures++;
         $display("FAIL reset_outputs pc=%h v=%b instr=%h if_pc=%h c=%b mis=%b halt=%b, want all zero",
                  dif.pc, dif.if_valid, dif.if_instr, dif.if_pc, dif.if_is_c, if_misalign, halted);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) cycle();
      checks++;
      if (dif.pc !== 17'h0 || dif.if_valid !== 1'b0) begin
         failures++;
         $display("FAIL boot_hold_park pc=%h v=%b, want pc=0 v=0", dif.pc, dif.if_valid);
      end
      boot_hold = 1'b0;
      cycle();
      checks++;
      if (dif.if_valid !== 1'b0) begin
         failures++;
         $display("FAIL boot_to_run_valid got %b want 0", dif.if_valid);
      end
      cycle();
      checks++;
      if (dif.if_valid !== 1'b1 || dif.if_pc !== 17'h0) begin
         failures++;
         $display("FAIL first_fetch v=%b if_pc=%h, want v=1 if_pc=0", dif.if_valid, dif.if_pc);
      end
   endtask

   task automatic test_mixed();
      mem[0] = 16'h0093; mem[1] = 16'h00A0;
      mem[2] = 16'h4501;
      mem[3] = 16'h0113; mem[4] = 16'h00B0;
      do_reset();
      boot_hold = 1'b0;
      cycle();
      cycle();
      checks++;
      if (dif.if_pc !== 17'h0 || dif.if_is_c !== 1'b0 || dif.if_instr !== 32'h00A00093) begin
         failures++;
         $display("FAIL mixed_0 if_pc=%h c=%b instr=%h, want 0/0/00a00093", dif.if_pc, dif.if_is_c, dif.if_instr);
      end
      cycle();
      checks++;
      if (dif.if_pc !== 17'h4 || dif.if_is_c !== 1'b1 || dif.if_instr !== 32'h00004501) begin
         failures++;
         $display("FAIL mixed_4 if_pc=%h c=%b instr=%h, want 4/1/00004501", dif.if_pc, dif.if_is_c, dif.if_instr);
      end
      cycle();
      checks++;
      if (dif.if_pc !== 17'h6 || dif.if_is_c !== 1'b0 || dif.if_instr !== 32'h00B00113 || dif.pc !== 17'hA) begin
         failures++;
         $display("FAIL mixed_6 if_pc=%h c=%b instr=%h pc=%h, want 6/0/00b00113/a",
                  dif.if_pc, dif.if_is_c, dif.if_instr, dif.pc);
      end
   endtask

   task automatic test_stall();
      do_reset();
      boot_hold = 1'b0;
      cycle();
      cycle();
      cycle();
      dif.dec_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (dif.pc !== 17'h6 || dif.if_pc !== 17'h4 || dif.if_instr !== 32'h00004501 || dif.if_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold[%0d] pc=%h if_pc=%h instr=%h v=%b, want 6/4/00004501/1",
                     i, dif.pc, dif.if_pc, dif.if_instr, dif.if_valid);
         end
      end
      dif.dec_ready = 1'b1;
      cycle();
      checks++;
      if (dif.if_pc !== 17'h6 || dif.if_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_release if_pc=%h v=%b, want 6/1", dif.if_pc, dif.if_valid);
      end
   endtask

   task automatic test_redirect();
      dif.dec_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 17'h00100;
      cycle();
      checks++;
      if (dif.if_valid !== 1'b0 || dif.pc !== 17'h100 || if_misalign !== 1'b0) begin
         failures++;
         $display("FAIL redirect_flush v=%b pc=%h mis=%b, want 0/100/0", dif.if_valid, dif.pc, if_misalign);
      end
      redirect_valid = 1'b0; dif.dec_ready = 1'b1;
      cycle();
      checks++;
      if (dif.if_valid !== 1'b1 || dif.if_pc !== 17'h100) begin
         failures++;
         $display("FAIL redirect_target v=%b if_pc=%h, want 1/100", dif.if_valid, dif.if_pc);
      end
      redirect_valid = 1'b1; redirect_pc = 17'h00101;
      cycle();
      redirect_valid = 1'b0;
      checks++;
      if (dif.pc !== 17'h100 || if_misalign !== 1'b1 || dif.if_valid !== 1'b0) begin
         failures++;
         $display("FAIL redirect_odd pc=%h mis=%b v=%b, want 100/1/0", dif.pc, if_misalign, dif.if_valid);
      end
   endtask

   task automatic test_halt();
      halt_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         checks++;
         if (halted !== 1'b1 || dif.if_valid !== 1'b0 || dif.pc !== 17'h100) begin
            failures++;
            $display("FAIL halt_hold[%0d] halted=%b v=%b pc=%h, want 1/0/100", i, halted, dif.if_valid, dif.pc);
         end
      end
      halt_req = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 17'h00200;
      cycle();
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || dif.pc !== 17'h200 || dif.if_valid !== 1'b0) begin
         failures++;
         $display("FAIL halt_resume halted=%b pc=%h v=%b, want 0/200/0", halted, dif.pc, dif.if_valid);
      end
      cycle();
      checks++;
      if (dif.if_valid !== 1'b1 || dif.if_pc !== 17'h200) begin
         failures++;
         $display("FAIL halt_resume_fetch v=%b if_pc=%h, want 1/200", dif.if_valid, dif.if_pc);
      end
   endtask

   task automatic test_wrap();
      mem[16'hFFFE] = 16'h0013;
      mem[16'hFFFF] = 16'h0001;
      mem[16'h0000] = 16'h0093;
      redirect_valid = 1'b1; redirect_pc = 17'h1FFFC;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      checks++;
      if (dif.if_pc !== 17'h1FFFC || dif.if_is_c !== 1'b0 || dif.pc !== 17'h0 || dif.if_instr !== 32'h00010013) begin
         failures++;
         $display("FAIL wrap_full if_pc=%h c=%b pc=%h instr=%h, want 1fffc/0/0/00010013",
                  dif.if_pc, dif.if_is_c, dif.pc, dif.if_instr);
      end
      redirect_valid = 1'b1; redirect_pc = 17'h1FFFE;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      checks++;
      if (dif.if_pc !== 17'h1FFFE || dif.if_is_c !== 1'b1 || dif.pc !== 17'h0 || dif.if_instr !== 32'h00000001) begin
         failures++;
         $display("FAIL wrap_c if_pc=%h c=%b pc=%h instr=%h, want 1fffe/1/0/00000001",
                  dif.if_pc, dif.if_is_c, dif.pc, dif.if_instr);
      end
   endtask

   task automatic test_midreset();
      dif.dec_ready = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b0;
      model_reset();
      #2;
      checks++;
      if ({dif.pc, dif.if_valid, dif.if_instr, dif.if_pc, dif.if_is_c, if_misalign, halted} !== '0) begin
         failures++;
         $display("FAIL midreset_async pc=%h v=%b instr=%h if_pc=%h c=%b mis=%b halt=%b, want all zero",
                  dif.pc, dif.if_valid, dif.if_instr, dif.if_pc, dif.if_is_c, if_misalign, halted);
      end
      boot_hold = 1'b0;
      dif.dec_ready = 1'b1;
      rst_n = 1'b1;
      cycle();
      checks++;
      if (dif.if_valid !== 1'b0 || dif.pc !== 17'h0) begin
         failures++;
         $display("FAIL midreset_boot v=%b pc=%h, want 0/0", dif.if_valid, dif.pc);
      end
      cycle();
      checks++;
      if (dif.if_valid !== 1'b1 || dif.if_pc !== 17'h0) begin
         failures++;
         $display("FAIL midreset_fetch v=%b if_pc=%h, want 1/0", dif.if_valid, dif.if_pc);
      end
   endtask

   task automatic test_random();
      logic [89:0] got, exp;
      do_reset();
      boot_hold = 1'b0;
      for (int i = 0; i < 600; i++) begin
         boot_hold      = ($urandom_range(0, 99) < 2);
         redirect_valid = ($urandom_range(0, 99) < 8);
         redirect_pc    = ($urandom_range(0, 99) < 10) ? 17'($urandom) : (17'($urandom) & 17'h003FE);
         halt_req       = ($urandom_range(0, 99) < 5);
         dif.dec_ready  = ($urandom_range(0, 99) < 70);
         cycle();
         got = {dif.pc, dif.if_valid, dif.if_instr, dif.if_pc, dif.if_is_c, if_misalign, halted};
         exp = {m_pc, m_v, m_instr, m_if_pc, m_c, m_mis, (m_st == 2)};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL rand[%0d] got pc=%h v=%b instr=%h if_pc=%h c=%b mis=%b halt=%b want pc=%h v=%b instr=%h if_pc=%h c=%b mis=%b halt=%b",
                     i, dif.pc, dif.if_valid, dif.if_instr, dif.if_pc, dif.if_is_c, if_misalign, halted,
                     m_pc, m_v, m_instr, m_if_pc, m_c, m_mis, (m_st == 2));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h0093; mem[1] = 16'h00A0;
      test_reset();
      test_mixed();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_midreset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
